// File: rtl/csr_io_unit.sv
// csr_io_unit: CSR-mapped GPIO block with synchronised inputs, sticky
// change flags (write-1-to-clear) and RW/RS/RC-writable output registers.
// Read data and hit are combinational; all state updates on the rising clk
// edge or on the asynchronous reset.
module csr_io_unit #(
    parameter int unsigned NUM_IN   = 2,
    parameter int unsigned IN_WIDTH = 18,
    parameter int unsigned NUM_OUT  = 2,
    parameter logic [11:0] CSR_BASE = 12'hF00
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         csr_valid,
    input  logic [1:0]                   csr_op,
    input  logic [11:0]                  csr_addr,
    input  logic [31:0]                  csr_wdata,
    output logic [31:0]                  csr_rdata,
    output logic                         csr_hit,
    input  logic [NUM_IN*IN_WIDTH-1:0]   gpio_in,
    output logic [NUM_OUT*32-1:0]        gpio_out
);

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    // Packed arrays share the bit layout of the flat pin/output buses.
    logic [NUM_IN-1:0][IN_WIDTH-1:0] sync1_q;
    logic [NUM_IN-1:0][IN_WIDTH-1:0] sync2_q;
    logic [NUM_IN-1:0][IN_WIDTH-1:0] prev_q;
    logic [NUM_IN-1:0][IN_WIDTH-1:0] flag_q;
    logic [NUM_IN-1:0][IN_WIDTH-1:0] flag_d;
    logic [NUM_IN-1:0][IN_WIDTH-1:0] flag_clr;
    logic [NUM_OUT-1:0][31:0]        out_q;
    logic [NUM_OUT-1:0][31:0]        out_d;

    logic [11:0] csr_off;
    csr_op_e     op;
    logic        wr_en;

    assign csr_off = csr_addr - CSR_BASE;
    assign op      = csr_op_e'(csr_op);
    assign wr_en   = csr_valid && (op != OP_READ);

    // Address decode and read-old data mux.
    always_comb begin
        csr_hit   = 1'b0;
        csr_rdata = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (csr_valid && (csr_off == 12'(i))) begin
                csr_hit   = 1'b1;
                csr_rdata = 32'(sync2_q[i]);
            end
            if (csr_valid && (csr_off == 12'(16 + i))) begin
                csr_hit   = 1'b1;
                csr_rdata = 32'(flag_q[i]);
            end
        end
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (csr_valid && (csr_off == 12'(32 + j))) begin
                csr_hit   = 1'b1;
                csr_rdata = out_q[j];
            end
        end
    end

    // Flag next state: any write op clears the written ones; the edge
    // detect is OR'd in afterwards so a simultaneous event always survives.
    always_comb begin
        flag_clr = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (wr_en && (csr_off == 12'(16 + i))) begin
                flag_clr[i] = csr_wdata[IN_WIDTH-1:0];
            end
        end
        flag_d = (flag_q & ~flag_clr) | (sync2_q ^ prev_q);
    end

    // Output register next state for RW/RS/RC.
    always_comb begin
        out_d = out_q;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            if (wr_en && (csr_off == 12'(32 + j))) begin
                case (op)
                    OP_RW:   out_d[j] = csr_wdata;
                    OP_RS:   out_d[j] = out_q[j] | csr_wdata;
                    OP_RC:   out_d[j] = out_q[j] & ~csr_wdata;
                    default: out_d[j] = out_q[j];
                endcase
            end
        end
    end

    // Two-stage pin synchroniser, edge-detect history and sticky flags.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            flag_q  <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            flag_q  <= flag_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign gpio_out = out_q;

endmodule

// File: tb/tb_csr_io_unit.sv
// Directed testbench for csr_io_unit with default parameters
// (NUM_IN=2, IN_WIDTH=18, NUM_OUT=2, CSR_BASE=12'hF00).
module tb_csr_io_unit;

    logic        clk;
    logic        res;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [35:0] gpio_in;
    logic [63:0] gpio_out;

    int checks = 0;
    int errors = 0;

    csr_io_unit #(
        .NUM_IN   (2),
        .IN_WIDTH (18),
        .NUM_OUT  (2),
        .CSR_BASE (12'hF00)
    ) dut (
        .clk       (clk),
        .res       (res),
        .csr_valid (csr_valid),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rd;
        logic [31:0] exp_o0;
        logic [31:0] exp_o1;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an access and check combinational hit/rdata within the cycle.
    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic exp_hit, input logic [31:0] exp_rd, input string name);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        #1;
        chk({name, " hit"}, {31'b0, csr_hit}, {31'b0, exp_hit});
        chk({name, " rdata"}, csr_rdata, exp_rd);
    endtask

    task automatic probe(input logic [11:0] addr, input logic [31:0] exp_rd, input string name);
        access(2'b00, addr, 32'h0, 1'b1, exp_rd, name);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b00, 12'hF20, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b1, 2'b00, 12'hF21, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b1, 2'b01, 12'hF20, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[3]  = '{1'b1, 2'b10, 12'hF20, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEFF, 32'h0000_0000};
        vecs[4]  = '{1'b1, 2'b11, 12'hF20, 32'hFF00_0000, 1'b1, 32'hDEAD_BEFF, 32'h00AD_BEFF, 32'h0000_0000};
        vecs[5]  = '{1'b1, 2'b00, 12'hF20, 32'hFFFF_FFFF, 1'b1, 32'h00AD_BEFF, 32'h00AD_BEFF, 32'h0000_0000};
        vecs[6]  = '{1'b1, 2'b01, 12'hF21, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[7]  = '{1'b1, 2'b01, 12'hF05, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[8]  = '{1'b1, 2'b01, 12'hF22, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[9]  = '{1'b1, 2'b01, 12'hF02, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[10] = '{1'b0, 2'b01, 12'hF20, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[11] = '{1'b1, 2'b01, 12'hF12, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[12] = '{1'b1, 2'b10, 12'hF30, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[13] = '{1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h00AD_BEFF, 32'h1234_5678};
        vecs[14] = '{1'b1, 2'b11, 12'hF21, 32'hFFFF_0000, 1'b1, 32'h1234_5678, 32'h00AD_BEFF, 32'h0000_5678};
        vecs[15] = '{1'b1, 2'b01, 12'hF10, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h00AD_BEFF, 32'h0000_5678};
        vecs[16] = '{1'b1, 2'b01, 12'hF00, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h00AD_BEFF, 32'h0000_5678};

        res       = 1'b1;
        csr_valid = 1'b0;
        csr_op    = 2'b00;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
        gpio_in   = '0;
        tick();
        tick();
        res = 1'b0;
        chk("reset out0", gpio_out[31:0], 32'h0);
        chk("reset out1", gpio_out[63:32], 32'h0);
        tick();

        // Table-driven CSR accesses with pins held at zero.
        for (int k = 0; k < NVEC; k++) begin
            csr_valid = vecs[k].valid;
            csr_op    = vecs[k].op;
            csr_addr  = vecs[k].addr;
            csr_wdata = vecs[k].wdata;
            #2;
            chk($sformatf("vec%0d hit", k), {31'b0, csr_hit}, {31'b0, vecs[k].exp_hit});
            chk($sformatf("vec%0d rdata", k), csr_rdata, vecs[k].exp_rd);
            tick();
            chk($sformatf("vec%0d out0", k), gpio_out[31:0], vecs[k].exp_o0);
            chk($sformatf("vec%0d out1", k), gpio_out[63:32], vecs[k].exp_o1);
        end

        // Pin-to-CSR latency on channel 1; the next edge (E) samples the pin.
        gpio_in = {18'h2A5A5, 18'h00000};
        probe(12'hF01, 32'h0, "lat in before E");
        tick();
        probe(12'hF01, 32'h0, "lat in after E");
        probe(12'hF11, 32'h0, "lat flag after E");
        tick();
        probe(12'hF01, 32'h0002_A5A5, "lat in after E+1");
        probe(12'hF11, 32'h0, "lat flag after E+1");
        tick();
        probe(12'hF11, 32'h0002_A5A5, "lat flag after E+2");
        access(2'b01, 12'hF11, 32'h5, 1'b1, 32'h0002_A5A5, "flag w1c");
        tick();
        probe(12'hF11, 32'h0002_A5A0, "flag after w1c");

        // Clearing through RC/RS, zero write and out-of-width bits.
        access(2'b11, 12'hF11, 32'h80, 1'b1, 32'h0002_A5A0, "flag rc");
        tick();
        access(2'b10, 12'hF11, 32'h20, 1'b1, 32'h0002_A520, "flag rs");
        tick();
        access(2'b01, 12'hF11, 32'h0, 1'b1, 32'h0002_A500, "flag zero");
        tick();
        access(2'b01, 12'hF11, 32'hFFFC_0000, 1'b1, 32'h0002_A500, "flag hi bits");
        tick();
        probe(12'hF11, 32'h0002_A500, "flag unchanged");

        // Input CSR write is ignored but still hits and returns old value.
        access(2'b01, 12'hF01, 32'hFFFF_FFFF, 1'b1, 32'h0002_A5A5, "in write");
        tick();
        probe(12'hF01, 32'h0002_A5A5, "in after write");

        // Set-wins: clear flag bit 0 while a new toggle is in sync2 != prev.
        gpio_in[0] = 1'b1;
        tick();
        tick();
        tick();
        probe(12'hF10, 32'h1, "ch0 flag set");
        gpio_in[0] = 1'b0;
        tick();
        tick();
        access(2'b01, 12'hF10, 32'h1, 1'b1, 32'h1, "setwin clr");
        tick();
        probe(12'hF10, 32'h1, "setwin kept");
        access(2'b01, 12'hF10, 32'h1, 1'b1, 32'h1, "plain clr");
        tick();
        probe(12'hF10, 32'h0, "plain cleared");

        // Asynchronous reset between edges with outputs and flags set.
        access(2'b01, 12'hF20, 32'hFFFF_FFFF, 1'b1, 32'h00AD_BEFF, "pre-rst out0");
        tick();
        chk("pre-rst gpio", gpio_out[31:0], 32'hFFFF_FFFF);
        csr_valid = 1'b1;
        csr_op    = 2'b00;
        csr_addr  = 12'hF11;
        #2;
        res = 1'b1;
        #1;
        chk("async out0", gpio_out[31:0], 32'h0);
        chk("async out1", gpio_out[63:32], 32'h0);
        chk("async flag1", csr_rdata, 32'h0);
        csr_addr = 12'hF01;
        #1;
        chk("async in1", csr_rdata, 32'h0);
        tick();
        res = 1'b0;

        // Pins still non-zero after reset: flags re-set after three edges.
        tick();
        probe(12'hF11, 32'h0, "post-rst flag e1");
        tick();
        probe(12'hF01, 32'h0002_A5A5, "post-rst in e2");
        probe(12'hF11, 32'h0, "post-rst flag e2");
        tick();
        probe(12'hF11, 32'h0002_A5A5, "post-rst flag e3");
        probe(12'hF20, 32'h0, "post-rst out0");

        csr_valid = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
